// File: rtl/arm_mem_pkg.sv
// Shared constants for the ARM data-side responder: default bases, MMIO register offsets, STATUS layout.
// Optional alignment checking is enabled by defining ARM_DMEM_ALIGN_CHECK_EN.
package arm_mem_pkg;

    localparam logic [31:0] DEF_DATA_BASE = 32'h0000_0800;
    localparam logic [31:0] DEF_MMIO_BASE = 32'h0000_0C00;
    localparam int unsigned MMIO_BYTES    = 64;

    localparam logic [5:0] OFF_LED    = 6'h00;
    localparam logic [5:0] OFF_TXDATA = 6'h04;
    localparam logic [5:0] OFF_STATUS = 6'h08;
    localparam logic [5:0] OFF_CYCLES = 6'h0C;
    localparam logic [5:0] OFF_ERR    = 6'h10;

    localparam int unsigned ST_EMPTY_BIT = 0;
    localparam int unsigned ST_FULL_BIT  = 1;
    localparam int unsigned ST_OVF_BIT   = 2;
    localparam int unsigned ST_COUNT_LSB = 8;

    localparam int unsigned ERR_RD_BIT = 0;
    localparam int unsigned ERR_WR_BIT = 1;

    // Assemble the STATUS read word from FIFO state.
    function automatic logic [31:0] pack_status(input logic [7:0] count, input logic ovf,
                                                input logic full, input logic empty);
        logic [31:0] s;
        s                     = 32'h0;
        s[ST_COUNT_LSB +: 8]  = count;
        s[ST_OVF_BIT]         = ovf;
        s[ST_FULL_BIT]        = full;
        s[ST_EMPTY_BIT]       = empty;
        return s;
    endfunction

endpackage

// File: rtl/console_tx_fifo.sv
// Console transmit byte FIFO with valid/ready drain and sticky overflow flag.
// A push into a full FIFO is accepted only when the head is popped in the same cycle.
module console_tx_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_push,
    input  logic [7:0]                    i_push_data,
    input  logic                          i_ready,
    input  logic                          i_ovf_clr,
    output logic [7:0]                    o_head_c,
    output logic                          o_valid_c,
    output logic                          o_full_c,
    output logic                          o_empty_c,
    output logic [$clog2(DEPTH):0]        o_count,
    output logic                          o_ovf
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;

    logic w_pop;
    logic w_push_ok;
    logic w_drop;

    assign o_full_c  = (r_count == CW'(DEPTH));
    assign o_empty_c = (r_count == '0);
    assign o_valid_c = !o_empty_c;
    assign w_pop     = o_valid_c && i_ready;
    assign w_push_ok = i_push && (!o_full_c || w_pop);
    assign w_drop    = i_push && o_full_c && !w_pop;
    assign o_head_c  = o_valid_c ? r_mem[r_rd_ptr] : 8'h00;
    assign o_count   = r_count;
    assign o_ovf     = r_ovf;

    // Storage is not reset; the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // A dropped byte in the same cycle as a clear keeps the flag set.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (i_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/arm_dmem_responder.sv
// Data-side responder for the single-cycle ARM core: word RAM plus MMIO page (LED, console TX, STATUS, CYCLES).
// Define ARM_DMEM_ALIGN_CHECK_EN to enable misalignment detection, write suppression and the ERR register.
module arm_dmem_responder
    import arm_mem_pkg::*;
#(
    parameter int unsigned RAM_WORDS = 256,
    parameter logic [31:0] DATA_BASE = DEF_DATA_BASE,
    parameter logic [31:0] MMIO_BASE = DEF_MMIO_BASE,
    parameter int unsigned TX_DEPTH  = 8,
    parameter int unsigned LED_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RESETn,
    input  logic                 MemWrite,
    input  logic [31:0]          ALUResult,
    input  logic [31:0]          WriteData,
    output logic [31:0]          ReadData,
    output logic [LED_WIDTH-1:0] LED,
    output logic [7:0]           TX_DATA,
    output logic                 TX_VALID,
    input  logic                 TX_READY
);

    localparam int unsigned RAW = $clog2(RAM_WORDS);
    localparam int unsigned CW  = $clog2(TX_DEPTH) + 1;

    logic [31:0]          r_ram [RAM_WORDS];
    logic [LED_WIDTH-1:0] r_led;
    logic [31:0]          r_cycles;

    logic [31:0]  w_addr;
    logic         w_ram_hit;
    logic         w_mmio_hit;
    logic [RAW-1:0] w_ram_idx;
    logic [5:0]   w_mmio_off;
    logic         w_misalign;
    logic         w_wr;
    logic         w_sel_led;
    logic         w_sel_tx;
    logic         w_sel_status;
    logic         w_sel_cyc;
    logic [31:0]  w_err_rd;
    logic [31:0]  w_rd;

    logic [7:0]    w_tx_head;
    logic          w_tx_valid;
    logic          w_tx_full;
    logic          w_tx_empty;
    logic [CW-1:0] w_tx_count;
    logic          w_tx_ovf;

    // Decode on the word address; the byte offset only matters for alignment checking.
    assign w_addr     = {ALUResult[31:2], 2'b00};
    assign w_ram_hit  = (w_addr >= DATA_BASE) && (w_addr < (DATA_BASE + 32'(RAM_WORDS * 4)));
    assign w_mmio_hit = (w_addr >= MMIO_BASE) && (w_addr < (MMIO_BASE + 32'(MMIO_BYTES)));
    assign w_ram_idx  = RAW'((w_addr - DATA_BASE) >> 2);
    assign w_mmio_off = 6'(w_addr - MMIO_BASE);

    assign w_wr         = MemWrite && !w_misalign;
    assign w_sel_led    = w_mmio_hit && (w_mmio_off == OFF_LED);
    assign w_sel_tx     = w_mmio_hit && (w_mmio_off == OFF_TXDATA);
    assign w_sel_status = w_mmio_hit && (w_mmio_off == OFF_STATUS);
    assign w_sel_cyc    = w_mmio_hit && (w_mmio_off == OFF_CYCLES);

`ifdef ARM_DMEM_ALIGN_CHECK_EN
    logic [1:0] r_err;
    logic [1:0] w_err_set;
    logic [1:0] w_err_clr;

    assign w_misalign = (w_ram_hit || w_mmio_hit) && (ALUResult[1:0] != 2'b00);

    always_comb begin
        w_err_set             = 2'b00;
        w_err_set[ERR_RD_BIT] = w_misalign && !MemWrite;
        w_err_set[ERR_WR_BIT] = w_misalign && MemWrite;
        w_err_clr             = (w_wr && w_mmio_hit && (w_mmio_off == OFF_ERR)) ? WriteData[1:0] : 2'b00;
    end

    // Set takes priority over a same-cycle write-one-to-clear.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_err <= 2'b00;
        end else begin
            r_err <= w_err_set | (r_err & ~w_err_clr);
        end
    end

    assign w_err_rd = {30'h0, r_err};
`else
    logic w_unused;

    assign w_misalign = 1'b0;
    assign w_err_rd   = 32'h0;
    assign w_unused   = ^ALUResult[1:0];
`endif

    always_ff @(posedge CLK) begin
        if (w_wr && w_ram_hit) begin
            r_ram[w_ram_idx] <= WriteData;
        end
    end

    // A CYCLES write takes priority over the increment.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_led    <= '0;
            r_cycles <= 32'h0;
        end else begin
            if (w_wr && w_sel_led) begin
                r_led <= WriteData[LED_WIDTH-1:0];
            end
            r_cycles <= (w_wr && w_sel_cyc) ? 32'h0 : r_cycles + 32'd1;
        end
    end

    console_tx_fifo #(
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk         (CLK),
        .rst_n       (RESETn),
        .i_push      (w_wr && w_sel_tx),
        .i_push_data (WriteData[7:0]),
        .i_ready     (TX_READY),
        .i_ovf_clr   (w_wr && w_sel_status),
        .o_head_c    (w_tx_head),
        .o_valid_c   (w_tx_valid),
        .o_full_c    (w_tx_full),
        .o_empty_c   (w_tx_empty),
        .o_count     (w_tx_count),
        .o_ovf       (w_tx_ovf)
    );

    // Zero-latency read mux; unmapped and write-only locations read zero.
    always_comb begin
        w_rd = 32'h0;
        if (w_ram_hit) begin
            w_rd = r_ram[w_ram_idx];
        end else if (w_mmio_hit) begin
            case (w_mmio_off)
                OFF_LED:    w_rd = 32'(r_led);
                OFF_STATUS: w_rd = pack_status(8'(w_tx_count), w_tx_ovf, w_tx_full, w_tx_empty);
                OFF_CYCLES: w_rd = r_cycles;
                OFF_ERR:    w_rd = w_err_rd;
                default:    w_rd = 32'h0;
            endcase
        end
    end

    assign ReadData = w_rd;
    assign LED      = r_led;
    assign TX_DATA  = w_tx_head;
    assign TX_VALID = w_tx_valid;

endmodule
